// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Owns the PC and issues word requests to instruction memory. A credit rule
//   (buffered + in-flight < DEPTH) keeps at most DEPTH words in play, so every
//   response always has a FIFO slot. Returned words are paired with their
//   request PC and delivered in order to decode. A redirect reloads the PC,
//   flushes the FIFO and marks all in-flight requests stale. If any are stale,
//   the unit sits in DRAIN until they have returned.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   imem_req_valid/ready/addr          word fetch request (addr = pc)
//   imem_rsp_valid/data                in-order response, no backpressure
//   redir_valid/redir_pc               taken jump/branch redirect
//   inst_valid/ready, inst, inst_pc    FIFO head to decode
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [CW-1:0]     count, count_n, outstanding, out_n, stale, stale_n;
    logic              req_valid_n;

    // Instruction FIFO and the in-order request-address queue.
    logic [31:0]       fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] aq_pc     [DEPTH];
    logic [PW-1:0]     aq_rd, aq_wr;

    logic accept, pop, push, rsp;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign accept        = imem_req_valid & imem_req_ready;
    assign pop           = inst_valid & inst_ready;
    assign rsp           = imem_rsp_valid;
    assign push          = (state == FETCH) & rsp & ~redir_valid;
    assign imem_req_addr = pc;
    assign inst_valid    = (count != '0);
    assign inst          = fifo_inst[rd_ptr];
    assign inst_pc       = fifo_pc[rd_ptr];

    always_comb begin
        state_n = state;
        pc_n    = pc;
        stale_n = stale;
        count_n = count + CW'(push) - CW'(pop);
        out_n   = outstanding + CW'(accept) - CW'(rsp);
        if (redir_valid) begin
            // A same-cycle accept is already in out_n and becomes stale.
            pc_n    = {redir_pc[ADDR_W-1:2], 2'b00};
            count_n = '0;
            stale_n = out_n;
            // With nothing left to drain, DRAIN would never exit; go FETCH.
            state_n = (out_n != '0) ? DRAIN : FETCH;
        end else begin
            if (accept) pc_n = pc + ADDR_W'(4);
            if (state == DRAIN && rsp) begin
                stale_n = stale - CW'(1);
                if (stale == CW'(1)) state_n = FETCH;
            end
        end
        // Registered copy of the credit rule, evaluated on next-state values.
        req_valid_n = (state_n == FETCH) &&
                      (({1'b0, count_n} + {1'b0, out_n}) < (CW + 1)'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            count          <= '0;
            outstanding    <= '0;
            stale          <= '0;
            imem_req_valid <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            aq_rd          <= '0;
            aq_wr          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst[i] <= '0;
                fifo_pc[i]   <= '0;
                aq_pc[i]     <= '0;
            end
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            count          <= count_n;
            outstanding    <= out_n;
            stale          <= stale_n;
            imem_req_valid <= req_valid_n;
            // The address queue tracks every request, stale or not.
            if (accept) begin
                aq_pc[aq_wr] <= pc;
                aq_wr        <= ptr_inc(aq_wr);
            end
            if (rsp) aq_rd <= ptr_inc(aq_rd);
            if (redir_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_inst[wr_ptr] <= imem_rsp_data;
                    fifo_pc[wr_ptr]   <= aq_pc[aq_rd];
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop) rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(DEPTH)));

endmodule
